// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: opcodes, datapath
// select codes, FSM states and the per-state control word.
package multicycle_control_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRC_A_PC     = 2'b00;
   localparam logic [1:0] SRC_A_RS1    = 2'b01;
   localparam logic [1:0] SRC_A_OLD_PC = 2'b10;

   localparam logic [1:0] SRC_B_RS2  = 2'b00;
   localparam logic [1:0] SRC_B_FOUR = 2'b01;
   localparam logic [1:0] SRC_B_IMM  = 2'b10;

   localparam logic [1:0] WB_ALUOUT = 2'b00;
   localparam logic [1:0] WB_MDR    = 2'b01;
   localparam logic [1:0] WB_PC4    = 2'b10;

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_EXEC_R    = 4'd2,
      S_EXEC_I    = 4'd3,
      S_ALU_WB    = 4'd4,
      S_MEM_ADDR  = 4'd5,
      S_MEM_LOAD  = 4'd6,
      S_LOAD_WB   = 4'd7,
      S_MEM_STORE = 4'd8,
      S_BRANCH    = 4'd9,
      S_BR_TGT    = 4'd10,
      S_JAL       = 4'd11,
      S_TRAP      = 4'd12
   } state_t;

   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       iord;
      logic       pc_write;
      logic       reg_write;
      logic [1:0] wb_sel;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       imm_arith;
      logic       trap;
   } ctrl_t;

   // Moore part of the control word; the FETCH strobes and the branch-target
   // pc_write depend on live inputs and are layered on top by the FSM.
   function automatic ctrl_t state_ctrl(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.mem_req   = 1'b1;
            c.alu_src_a = SRC_A_PC;
            c.alu_src_b = SRC_B_FOUR;
            c.alu_op    = ALUOP_ADD;
         end
         S_EXEC_R: begin
            c.alu_src_a = SRC_A_RS1;
            c.alu_src_b = SRC_B_RS2;
            c.alu_op    = ALUOP_FUNCT;
         end
         S_EXEC_I: begin
            c.alu_src_a = SRC_A_RS1;
            c.alu_src_b = SRC_B_IMM;
            c.alu_op    = ALUOP_FUNCT;
            c.imm_arith = 1'b1;
         end
         S_ALU_WB: begin
            c.reg_write = 1'b1;
            c.wb_sel    = WB_ALUOUT;
         end
         S_MEM_ADDR: begin
            c.alu_src_a = SRC_A_RS1;
            c.alu_src_b = SRC_B_IMM;
            c.alu_op    = ALUOP_ADD;
         end
         S_MEM_LOAD: begin
            c.mem_req = 1'b1;
            c.iord    = 1'b1;
         end
         S_LOAD_WB: begin
            c.reg_write = 1'b1;
            c.wb_sel    = WB_MDR;
         end
         S_MEM_STORE: begin
            c.mem_req = 1'b1;
            c.iord    = 1'b1;
            c.mem_we  = 1'b1;
         end
         S_BRANCH: begin
            c.alu_src_a = SRC_A_RS1;
            c.alu_src_b = SRC_B_RS2;
            c.alu_op    = ALUOP_SUB;
         end
         S_BR_TGT: begin
            c.alu_src_a = SRC_A_OLD_PC;
            c.alu_src_b = SRC_B_IMM;
            c.alu_op    = ALUOP_ADD;
         end
         S_JAL: begin
            c.alu_src_a = SRC_A_OLD_PC;
            c.alu_src_b = SRC_B_IMM;
            c.alu_op    = ALUOP_ADD;
            c.pc_write  = 1'b1;
            c.reg_write = 1'b1;
            c.wb_sel    = WB_PC4;
         end
         S_TRAP: c.trap = 1'b1;
         default: ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/multicycle_control_instret_counter.sv
// Retired-instruction counter; wraps naturally at 2^W.
module multicycle_control_instret_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst)
         count <= '0;
      else if (en)
         count <= count + 1'b1;
   end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle RV32I core: sequences the shared ALU,
// memory port and register file, traps on unsupported encodings.
//
//   state       | meaning
//   ------------+--------------------------------------------------
//   FETCH       | request IR at PC; on ready load IR, PC <= PC+4
//   DECODE      | one idle cycle, dispatch on opcode
//   EXEC_R      | rs1 op rs2
//   EXEC_I      | rs1 op imm (funct7 forced to zero)
//   ALU_WB      | write ALUOut to rd, retire
//   MEM_ADDR    | rs1 + imm address calculation
//   MEM_LOAD    | data read at ALUOut, wait for ready
//   LOAD_WB     | write MDR to rd, retire
//   MEM_STORE   | data write at ALUOut, retire on ready
//   BRANCH      | rs1 - rs2 compare, latch taken
//   BR_TGT      | old_pc + imm, PC written if taken, retire
//   JAL         | PC <= old_pc + imm, rd <= old_pc + 4, retire
//   TRAP        | unsupported encoding, wait for trap_ack
module multicycle_control
   import multicycle_control_pkg::*;
#(
   parameter int INSTRET_W       = 32,
   parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [6:0]           opcode,
   input  logic [2:0]           funct3,
   input  logic                 zero,
   input  logic                 mem_ready,
   input  logic                 trap_ack,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic                 iord,
   output logic                 ir_write,
   output logic                 pc_write,
   output logic                 reg_write,
   output logic [1:0]           wb_sel,
   output logic [1:0]           alu_src_a,
   output logic [1:0]           alu_src_b,
   output logic [1:0]           alu_op,
   output logic                 imm_arith,
   output logic                 trap,
   output logic [INSTRET_W-1:0] instret
);

   localparam state_t ILLEGAL_NXT = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;

   state_t state_q;
   state_t state_nxt;
   ctrl_t  ctrl_q;
   ctrl_t  ctrl_nxt;

   logic mem_done;
   logic fetch_done;
   logic opcode_legal;
   logic branch_ok;
   logic taken;
   logic retire;

   // A request only completes while mem_req is actually on the bus, so a
   // ready seen in the cycle right after reset is ignored.
   assign mem_done   = ctrl_q.mem_req & mem_ready;
   assign fetch_done = (state_q == S_FETCH) & mem_done;

   assign branch_ok = (funct3 == F3_BEQ) | (funct3 == F3_BNE);
   assign taken     = ((funct3 == F3_BEQ) & zero) | ((funct3 == F3_BNE) & ~zero);

   always_comb begin
      opcode_legal = 1'b0;
      case (opcode)
         OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL: opcode_legal = 1'b1;
         default: opcode_legal = 1'b0;
      endcase
   end

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         S_FETCH:     if (fetch_done) state_nxt = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_R:              state_nxt = S_EXEC_R;
               OP_I:              state_nxt = S_EXEC_I;
               OP_LOAD, OP_STORE: state_nxt = S_MEM_ADDR;
               OP_BRANCH:         state_nxt = S_BRANCH;
               OP_JAL:            state_nxt = S_JAL;
               default:           state_nxt = ILLEGAL_NXT;
            endcase
         end
         S_EXEC_R:    state_nxt = S_ALU_WB;
         S_EXEC_I:    state_nxt = S_ALU_WB;
         S_ALU_WB:    state_nxt = S_FETCH;
         S_MEM_ADDR:  state_nxt = (opcode == OP_LOAD) ? S_MEM_LOAD : S_MEM_STORE;
         S_MEM_LOAD:  if (mem_done) state_nxt = S_LOAD_WB;
         S_LOAD_WB:   state_nxt = S_FETCH;
         S_MEM_STORE: if (mem_done) state_nxt = S_FETCH;
         S_BRANCH:    state_nxt = branch_ok ? S_BR_TGT : ILLEGAL_NXT;
         S_BR_TGT:    state_nxt = S_FETCH;
         S_JAL:       state_nxt = S_FETCH;
         S_TRAP:      if (trap_ack) state_nxt = S_FETCH;
         default:     state_nxt = S_FETCH;
      endcase
   end

   always_comb begin
      retire = 1'b0;
      case (state_q)
         S_ALU_WB, S_LOAD_WB, S_BR_TGT, S_JAL: retire = 1'b1;
         S_MEM_STORE: retire = mem_done;
         S_DECODE:    retire = !TRAP_ON_ILLEGAL && !opcode_legal;
         S_BRANCH:    retire = !TRAP_ON_ILLEGAL && !branch_ok;
         default:     retire = 1'b0;
      endcase
   end

   // Control word for the coming state; the branch decision is captured here
   // at the end of BRANCH and becomes the BR_TGT pc_write.
   always_comb begin
      ctrl_nxt = state_ctrl(state_nxt);
      if (state_nxt == S_BR_TGT)
         ctrl_nxt.pc_write = taken;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         ctrl_q  <= '0;
      end else begin
         state_q <= state_nxt;
         ctrl_q  <= ctrl_nxt;
      end
   end

   assign mem_req   = ctrl_q.mem_req;
   assign mem_we    = ctrl_q.mem_we;
   assign iord      = ctrl_q.iord;
   assign ir_write  = fetch_done;
   assign pc_write  = ctrl_q.pc_write | fetch_done;
   assign reg_write = ctrl_q.reg_write;
   assign wb_sel    = ctrl_q.wb_sel;
   assign alu_src_a = ctrl_q.alu_src_a;
   assign alu_src_b = ctrl_q.alu_src_b;
   assign alu_op    = ctrl_q.alu_op;
   assign imm_arith = ctrl_q.imm_arith;
   assign trap      = ctrl_q.trap;

   multicycle_control_instret_counter #(
      .W (INSTRET_W)
   ) u_instret (
      .clk   (clk),
      .rst   (rst),
      .en    (retire),
      .count (instret)
   );

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction timing/strobe model with
// randomized stalls, two parameterizations (trapping and NOP-on-illegal).
module tb_multicycle_control;

   localparam logic [6:0] T_R   = 7'b0110011;
   localparam logic [6:0] T_I   = 7'b0010011;
   localparam logic [6:0] T_LD  = 7'b0000011;
   localparam logic [6:0] T_ST  = 7'b0100011;
   localparam logic [6:0] T_BR  = 7'b1100011;
   localparam logic [6:0] T_JAL = 7'b1101111;
   localparam logic [6:0] T_BAD = 7'b1111111;

   logic       clk = 1'b0;
   logic       rst_a, rst_b;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       zero, mem_ready, trap_ack;

   logic       a_mem_req, a_mem_we, a_iord, a_ir_write, a_pc_write, a_reg_write, a_imm, a_trap;
   logic [1:0] a_wb, a_sa, a_sb, a_op;
   logic [31:0] a_instret;
   logic       b_mem_req, b_mem_we, b_iord, b_ir_write, b_pc_write, b_reg_write, b_imm, b_trap;
   logic [1:0] b_wb, b_sa, b_sb, b_op;
   logic [3:0] b_instret;

   logic       sel;
   logic       o_mem_req, o_mem_we, o_iord, o_ir_write, o_pc_write, o_reg_write, o_imm, o_trap;
   logic [1:0] o_wb, o_sa, o_sb, o_op;
   logic [31:0] o_instret;

   int n_cmp = 0;
   int n_err = 0;
   int mdl_instret = 0;

   logic [1:0] r_op [64];
   logic [1:0] r_sa [64];
   logic [1:0] r_sb [64];
   logic [1:0] r_wb [64];
   logic       r_rw [64];
   logic       r_pw [64];
   logic       r_imm [64];

   always #5 clk = ~clk;

   multicycle_control dut_a (
      .clk(clk), .rst(rst_a), .opcode(opcode), .funct3(funct3), .zero(zero),
      .mem_ready(mem_ready), .trap_ack(trap_ack),
      .mem_req(a_mem_req), .mem_we(a_mem_we), .iord(a_iord), .ir_write(a_ir_write),
      .pc_write(a_pc_write), .reg_write(a_reg_write), .wb_sel(a_wb),
      .alu_src_a(a_sa), .alu_src_b(a_sb), .alu_op(a_op), .imm_arith(a_imm),
      .trap(a_trap), .instret(a_instret)
   );

   multicycle_control #(.INSTRET_W(4), .TRAP_ON_ILLEGAL(1'b0)) dut_b (
      .clk(clk), .rst(rst_b), .opcode(opcode), .funct3(funct3), .zero(zero),
      .mem_ready(mem_ready), .trap_ack(trap_ack),
      .mem_req(b_mem_req), .mem_we(b_mem_we), .iord(b_iord), .ir_write(b_ir_write),
      .pc_write(b_pc_write), .reg_write(b_reg_write), .wb_sel(b_wb),
      .alu_src_a(b_sa), .alu_src_b(b_sb), .alu_op(b_op), .imm_arith(b_imm),
      .trap(b_trap), .instret(b_instret)
   );

   always_comb begin
      if (sel) begin
         o_mem_req = b_mem_req; o_mem_we = b_mem_we; o_iord = b_iord; o_ir_write = b_ir_write;
         o_pc_write = b_pc_write; o_reg_write = b_reg_write; o_imm = b_imm; o_trap = b_trap;
         o_wb = b_wb; o_sa = b_sa; o_sb = b_sb; o_op = b_op; o_instret = {28'd0, b_instret};
      end else begin
         o_mem_req = a_mem_req; o_mem_we = a_mem_we; o_iord = a_iord; o_ir_write = a_ir_write;
         o_pc_write = a_pc_write; o_reg_write = a_reg_write; o_imm = a_imm; o_trap = a_trap;
         o_wb = a_wb; o_sa = a_sa; o_sb = a_sb; o_op = a_op; o_instret = a_instret;
      end
   end

   // Leaves the selected DUT at the start of its first requesting FETCH cycle.
   task automatic do_reset(input logic which);
      sel = which;
      rst_a = 1'b1; rst_b = 1'b1;
      mem_ready = 1'b0; trap_ack = 1'b0; opcode = '0; funct3 = '0; zero = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      if (which) rst_b = 1'b0; else rst_a = 1'b0;
      mdl_instret = 0;
      @(posedge clk); #1;
   endtask

   // One instruction from its first FETCH cycle to the next FETCH. fs/ds are
   // the fetch and data stall counts; everything expected comes from the
   // published per-class latencies and strobe rules.
   task automatic run_instr(input logic [6:0] opc, input logic [2:0] f3, input logic zb,
                            input int fs, input int ds, input string tag);
      int cyc, exp_pw, exp_rw, exp_we, exp_dreq;
      int n_freq, n_dreq, n_iw, n_pw, n_rw, n_we, n_tr;
      logic [1:0] exp_wb, wb_seen;
      logic [31:0] exp_inst;
      logic mem_op;
      logic rdy [64];
      exp_pw = 1; exp_rw = 0; exp_we = 0; exp_dreq = 0; exp_wb = 2'b00; mem_op = 1'b0;
      case (opc)
         T_R, T_I: begin cyc = fs + 4; exp_rw = 1; exp_wb = 2'b00; end
         T_LD: begin cyc = fs + ds + 5; exp_rw = 1; exp_wb = 2'b01; exp_dreq = ds + 1; mem_op = 1'b1; end
         T_ST: begin cyc = fs + ds + 4; exp_we = ds + 1; exp_dreq = ds + 1; mem_op = 1'b1; end
         T_BR: begin
            if (f3 == 3'b000 || f3 == 3'b001) begin
               cyc = fs + 4;
               if ((f3 == 3'b000 && zb) || (f3 == 3'b001 && !zb)) exp_pw = 2;
            end else
               cyc = fs + 3;
         end
         T_JAL: begin cyc = fs + 3; exp_rw = 1; exp_wb = 2'b10; exp_pw = 2; end
         default: cyc = fs + 2;
      endcase
      for (int c = 0; c < 64; c++) rdy[c] = 1'($urandom_range(0, 1));
      for (int c = 0; c < fs; c++) rdy[c] = 1'b0;
      rdy[fs] = 1'b1;
      if (mem_op) begin
         for (int c = fs + 3; c < fs + 3 + ds; c++) rdy[c] = 1'b0;
         rdy[fs + 3 + ds] = 1'b1;
      end
      n_freq = 0; n_dreq = 0; n_iw = 0; n_pw = 0; n_rw = 0; n_we = 0; n_tr = 0; wb_seen = 2'b11;
      for (int c = 0; c < cyc; c++) begin
         mem_ready = rdy[c];
         trap_ack  = 1'($urandom_range(0, 1));
         if (c <= fs) begin
            opcode = 7'($urandom); funct3 = 3'($urandom); zero = 1'($urandom);
         end else begin
            opcode = opc; funct3 = f3; zero = zb;
         end
         @(negedge clk);
         r_op[c] = o_op; r_sa[c] = o_sa; r_sb[c] = o_sb; r_wb[c] = o_wb;
         r_rw[c] = o_reg_write; r_pw[c] = o_pc_write; r_imm[c] = o_imm;
         if (o_mem_req && !o_iord) n_freq++;
         if (o_mem_req && o_iord) n_dreq++;
         if (o_mem_req && o_mem_we) n_we++;
         n_iw += int'(o_ir_write);
         n_pw += int'(o_pc_write);
         n_rw += int'(o_reg_write);
         n_tr += int'(o_trap);
         if (o_reg_write) wb_seen = o_wb;
         @(posedge clk); #1;
      end
      mdl_instret++;
      exp_inst = sel ? 32'(mdl_instret % 16) : 32'(mdl_instret);

      n_cmp++; if (n_freq !== fs + 1) begin n_err++; $display("FAIL %s fetch_req_cycles: got %0d expected %0d", tag, n_freq, fs + 1); end
      n_cmp++; if (n_dreq !== exp_dreq) begin n_err++; $display("FAIL %s data_req_cycles: got %0d expected %0d", tag, n_dreq, exp_dreq); end
      n_cmp++; if (n_we !== exp_we) begin n_err++; $display("FAIL %s mem_we_cycles: got %0d expected %0d", tag, n_we, exp_we); end
      n_cmp++; if (n_iw !== 1) begin n_err++; $display("FAIL %s ir_write_count: got %0d expected 1", tag, n_iw); end
      n_cmp++; if (n_pw !== exp_pw) begin n_err++; $display("FAIL %s pc_write_count: got %0d expected %0d", tag, n_pw, exp_pw); end
      n_cmp++; if (n_rw !== exp_rw) begin n_err++; $display("FAIL %s reg_write_count: got %0d expected %0d", tag, n_rw, exp_rw); end
      if (exp_rw == 1) begin
         n_cmp++; if (wb_seen !== exp_wb) begin n_err++; $display("FAIL %s wb_sel: got %b expected %b", tag, wb_seen, exp_wb); end
      end
      n_cmp++; if (n_tr !== 0) begin n_err++; $display("FAIL %s trap_cycles: got %0d expected 0", tag, n_tr); end
      n_cmp++;
      if (o_mem_req !== 1'b1 || o_iord !== 1'b0) begin
         n_err++; $display("FAIL %s next_fetch_after_%0d_cycles: got req=%b iord=%b expected req=1 iord=0", tag, cyc, o_mem_req, o_iord);
      end
      n_cmp++; if (o_instret !== exp_inst) begin n_err++; $display("FAIL %s instret: got %0d expected %0d", tag, o_instret, exp_inst); end
   endtask

   task automatic test_reset();
      sel = 1'b0;
      rst_a = 1'b1; rst_b = 1'b1;
      mem_ready = 1'b1; trap_ack = 1'b1; opcode = T_R; funct3 = 3'b000; zero = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({a_mem_req, a_mem_we, a_iord, a_ir_write, a_pc_write, a_reg_write, a_imm, a_trap,
           a_wb, a_sa, a_sb, a_op} !== 16'd0) begin
         n_err++; $display("FAIL reset_outputs: got nonzero control outputs, expected all 0");
      end
      n_cmp++; if (a_instret !== 32'd0) begin n_err++; $display("FAIL reset_instret: got %0d expected 0", a_instret); end
      @(posedge clk); #1;
      rst_a = 1'b0;
      mdl_instret = 0;
      @(negedge clk);
      n_cmp++;
      if (a_mem_req !== 1'b0 || a_ir_write !== 1'b0) begin
         n_err++; $display("FAIL reset_first_cycle: got req=%b ir_write=%b expected 0 0", a_mem_req, a_ir_write);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (a_mem_req !== 1'b1 || a_iord !== 1'b0 || a_sa !== 2'b00 || a_sb !== 2'b01 || a_op !== 2'b00) begin
         n_err++; $display("FAIL fetch_controls: got req=%b iord=%b a=%b b=%b op=%b expected 1 0 00 01 00",
                           a_mem_req, a_iord, a_sa, a_sb, a_op);
      end
   endtask

   task automatic test_r_type();
      int early_rw;
      run_instr(T_R, 3'($urandom), 1'b0, 0, 0, "r_type");
      early_rw = int'(r_rw[0]) + int'(r_rw[1]) + int'(r_rw[2]);
      n_cmp++; if (early_rw !== 0 || r_rw[3] !== 1'b1) begin n_err++; $display("FAIL r_reg_write_timing: got early=%0d c4=%b expected 0 1", early_rw, r_rw[3]); end
      n_cmp++;
      if (r_op[2] !== 2'b10 || r_sa[2] !== 2'b01 || r_sb[2] !== 2'b00) begin
         n_err++; $display("FAIL exec_r_controls: got op=%b a=%b b=%b expected 10 01 00", r_op[2], r_sa[2], r_sb[2]);
      end
      run_instr(T_I, 3'($urandom), 1'b0, 1, 0, "i_type");
      n_cmp++;
      if (r_imm[3] !== 1'b1 || r_sb[3] !== 2'b10 || r_op[3] !== 2'b10 || r_imm[4] !== 1'b0) begin
         n_err++; $display("FAIL exec_i_controls: got imm=%b b=%b op=%b next_imm=%b expected 1 10 10 0", r_imm[3], r_sb[3], r_op[3], r_imm[4]);
      end
   endtask

   task automatic test_load_stall();
      run_instr(T_LD, 3'b010, 1'b0, 2, 1, "load_stall");
      n_cmp++;
      if (r_rw[7] !== 1'b1 || r_wb[7] !== 2'b01) begin
         n_err++; $display("FAIL load_wb_cycle8: got rw=%b wb=%b expected 1 01", r_rw[7], r_wb[7]);
      end
      run_instr(T_ST, 3'b010, 1'b0, 0, 2, "store_stall");
   endtask

   task automatic test_branch();
      run_instr(T_BR, 3'b000, 1'b1, 0, 0, "beq_taken");
      n_cmp++;
      if (r_pw[3] !== 1'b1 || r_sa[3] !== 2'b10 || r_sb[3] !== 2'b10 || r_op[3] !== 2'b00) begin
         n_err++; $display("FAIL beq_br_tgt: got pw=%b a=%b b=%b op=%b expected 1 10 10 00", r_pw[3], r_sa[3], r_sb[3], r_op[3]);
      end
      n_cmp++; if (r_op[2] !== 2'b01) begin n_err++; $display("FAIL branch_alu_op: got %b expected 01", r_op[2]); end
      run_instr(T_BR, 3'b001, 1'b1, 0, 0, "bne_not_taken");
      n_cmp++; if (r_pw[3] !== 1'b0) begin n_err++; $display("FAIL bne_pc_write: got %b expected 0", r_pw[3]); end
   endtask

   task automatic test_jal();
      run_instr(T_JAL, 3'($urandom), 1'b0, 0, 0, "jal");
      n_cmp++;
      if (r_pw[2] !== 1'b1 || r_rw[2] !== 1'b1 || r_wb[2] !== 2'b10) begin
         n_err++; $display("FAIL jal_strobes: got pw=%b rw=%b wb=%b expected 1 1 10", r_pw[2], r_rw[2], r_wb[2]);
      end
   endtask

   // Trapping configuration: pre is the cycle count before TRAP is entered.
   task automatic test_trap(input logic [6:0] opc, input logic [2:0] f3, input int pre, input string tag);
      int n_tr, n_str;
      n_tr = 0; n_str = 0;
      for (int c = 0; c < pre; c++) begin
         mem_ready = (c == 0); trap_ack = 1'b0;
         opcode = opc; funct3 = f3; zero = 1'($urandom);
         @(negedge clk);
         n_tr += int'(o_trap);
         @(posedge clk); #1;
      end
      n_cmp++; if (n_tr !== 0) begin n_err++; $display("FAIL %s early_trap: got %0d cycles expected 0", tag, n_tr); end
      for (int k = 0; k < 5; k++) begin
         trap_ack = (k == 4);
         mem_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         n_tr += int'(o_trap);
         n_str += int'(o_mem_req | o_reg_write | o_pc_write | o_ir_write);
         @(posedge clk); #1;
      end
      n_cmp++; if (n_tr !== 5) begin n_err++; $display("FAIL %s trap_cycles: got %0d expected 5", tag, n_tr); end
      n_cmp++; if (n_str !== 0) begin n_err++; $display("FAIL %s trap_strobes: got %0d expected 0", tag, n_str); end
      n_cmp++;
      if (o_trap !== 1'b0 || o_mem_req !== 1'b1 || o_iord !== 1'b0) begin
         n_err++; $display("FAIL %s trap_exit: got trap=%b req=%b iord=%b expected 0 1 0", tag, o_trap, o_mem_req, o_iord);
      end
      n_cmp++; if (o_instret !== 32'(mdl_instret)) begin n_err++; $display("FAIL %s trap_instret: got %0d expected %0d", tag, o_instret, mdl_instret); end
   endtask

   task automatic test_random();
      logic [6:0] ops [6];
      logic [6:0] opc;
      logic [2:0] f3;
      ops[0] = T_R; ops[1] = T_I; ops[2] = T_LD; ops[3] = T_ST; ops[4] = T_BR; ops[5] = T_JAL;
      for (int i = 0; i < 40; i++) begin
         opc = ops[$urandom_range(0, 5)];
         f3  = (opc == T_BR) ? 3'($urandom_range(0, 1)) : 3'($urandom);
         run_instr(opc, f3, 1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), "random");
      end
   endtask

   task automatic test_reset_mid_store();
      for (int c = 0; c < 4; c++) begin
         mem_ready = (c == 0); opcode = T_ST; funct3 = 3'b010; trap_ack = 1'b0;
         if (c == 3) rst_a = 1'b1;
         @(negedge clk);
         if (c == 3) begin
            n_cmp++;
            if (o_mem_req !== 1'b1 || o_mem_we !== 1'b1 || o_iord !== 1'b1) begin
               n_err++; $display("FAIL store_before_reset: got req=%b we=%b iord=%b expected 1 1 1", o_mem_req, o_mem_we, o_iord);
            end
         end
         @(posedge clk); #1;
      end
      mem_ready = 1'b1; rst_a = 1'b0; mdl_instret = 0;
      @(negedge clk);
      n_cmp++; if (o_mem_req !== 1'b0 || o_mem_we !== 1'b0) begin n_err++; $display("FAIL reset_drops_req: got req=%b we=%b expected 0 0", o_mem_req, o_mem_we); end
      n_cmp++; if (o_instret !== 32'd0) begin n_err++; $display("FAIL reset_clears_instret: got %0d expected 0", o_instret); end
      @(posedge clk); #1;
      @(negedge clk);
      n_cmp++;
      if (o_mem_req !== 1'b1 || o_iord !== 1'b0 || o_mem_we !== 1'b0) begin
         n_err++; $display("FAIL reset_to_fetch: got req=%b iord=%b we=%b expected 1 0 0", o_mem_req, o_iord, o_mem_we);
      end
   endtask

   task automatic test_illegal_nop();
      do_reset(1'b1);
      run_instr(T_BAD, 3'($urandom), 1'b0, int'($urandom_range(0, 2)), 0, "nop_illegal_opcode");
      run_instr(T_BR, 3'b110, 1'b1, 0, 0, "nop_bad_branch_f3");
      n_cmp++; if (o_instret !== 32'd2) begin n_err++; $display("FAIL nop_retire_count: got %0d expected 2", o_instret); end
   endtask

   task automatic test_wrap();
      do_reset(1'b1);
      for (int i = 0; i < 16; i++) begin
         run_instr(T_R, 3'($urandom), 1'b0, 0, 0, "wrap");
         if (i == 14) begin
            n_cmp++; if (o_instret !== 32'd15) begin n_err++; $display("FAIL wrap_at_15: got %0d expected 15", o_instret); end
         end
      end
      n_cmp++; if (o_instret !== 32'd0) begin n_err++; $display("FAIL wrap_to_zero: got %0d expected 0", o_instret); end
   endtask

   initial begin
      test_reset();
      test_r_type();
      test_load_stall();
      test_branch();
      test_jal();
      test_trap(T_BAD, 3'b000, 2, "trap_opcode");
      test_trap(T_BR, 3'b100, 3, "trap_branch_f3");
      test_random();
      test_reset_mid_store();
      test_illegal_nop();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multi-cycle RV32I core.
- Sequences fetch/decode/execute/memory/writeback over the shared datapath: one ALU, one memory port, one register file.
- Drives alu_op into the ALU control decoder, plus mux selects and write enables.
- Handshakes with memory via req/ready; traps on unsupported opcodes; counts retired instructions.

Parameters:
- INSTRET_W, 32, width of retired-instruction counter (wraps modulo 2^INSTRET_W).
- TRAP_ON_ILLEGAL, 1, 1: illegal opcode/funct3 enters TRAP; 0: treated as NOP (back to FETCH, retires).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  7  IR[6:0], valid from DECODE onward.
- funct3  in  3  IR[14:12].
- zero  in  1  ALU zero flag, combinational from current ALU op.
- mem_ready  in  1  memory completes the current request this cycle.
- trap_ack  in  1  exits TRAP.
- mem_req  out  1  memory request, held until mem_ready.
- mem_we  out  1  store request qualifier (with mem_req).
- iord  out  1  0: address=PC, 1: address=ALUOut.
- ir_write  out  1  load IR and old_pc.
- pc_write  out  1  PC <= ALU result.
- reg_write  out  1  regfile write.
- wb_sel  out  2  00 ALUOut, 01 MDR, 10 old_pc+4.
- alu_src_a  out  2  00 PC, 01 rs1, 10 old_pc.
- alu_src_b  out  2  00 rs2, 01 const 4, 10 imm.
- alu_op  out  2  00 add, 01 sub, 10 funct-decoded.
- imm_arith  out  1  datapath forces funct7=0 into ALU decode (I-type).
- trap  out  1  high while in TRAP.
- instret  out  INSTRET_W  retired count.

Behaviour:
- Reset: state=FETCH; all outputs 0; instret=0. Reset wins over any in-flight memory request; mem_req drops the next cycle.
- FETCH:
  - mem_req=1, iord=0, alu_src_a=00, alu_src_b=01, alu_op=00.
  - On mem_ready: ir_write=1, pc_write=1 (PC+4), go to DECODE. Else stay.
  - Strobes fire only in the mem_ready cycle.
- DECODE: one cycle, no strobes. Next state by opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 or 0100011 -> MEM_ADDR
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - other -> TRAP (or FETCH+retire if TRAP_ON_ILLEGAL=0)
- EXEC_R: a=01, b=00, alu_op=10 -> ALU_WB.
- EXEC_I: a=01, b=10, alu_op=10, imm_arith=1 -> ALU_WB.
- ALU_WB: reg_write=1, wb_sel=00, retire -> FETCH.
- MEM_ADDR: a=01, b=10, alu_op=00. Load -> MEM_LOAD, store -> MEM_STORE.
- MEM_LOAD: mem_req=1, iord=1, mem_we=0. On mem_ready -> LOAD_WB.
- LOAD_WB: reg_write=1, wb_sel=01, retire -> FETCH.
- MEM_STORE: mem_req=1, iord=1, mem_we=1. On mem_ready: retire -> FETCH.
- BRANCH:
  - a=01, b=00, alu_op=01.
  - taken = (funct3==000 & zero) | (funct3==001 & ~zero).
  - Other funct3 -> TRAP (per parameter).
  - Next cycle BR_TGT: a=10, b=10, alu_op=00, pc_write=taken_reg, retire -> FETCH. taken is registered at the end of BRANCH.
- JAL: a=10, b=10, alu_op=00, pc_write=1, reg_write=1, wb_sel=10, retire -> FETCH.
- TRAP: trap=1, no other strobes. trap_ack -> FETCH. No retire.
- Latency with mem_ready tied high:
  - R/I: 4 cycles.
  - load: 5.
  - store: 4.
  - branch: 4.
  - jal: 3.
- Each mem_ready stall adds 1 cycle.
- mem_ready outside a request state is ignored.
- Retire: instret increments by exactly 1 in the retiring cycle.
- Outputs are Moore-decoded from state, except FETCH strobes and BR_TGT pc_write, which are gated as above.

Decomposition:
- Shared package holds:
  - opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL).
  - alu_op encodings (ALUOP_ADD/SUB/FUNCT).
  - src/wb select encodings.
  - state enum (4-bit).
- One natural sub-module: instret_counter (enable, wrap).

Test Plan:
- R-type: opcode=0110011, mem_ready=1 -> states FETCH, DECODE, EXEC_R, ALU_WB; reg_write only in cycle 4; alu_op=10 in EXEC_R; instret 0->1.
- Load with fetch stall 2 cycles and data stall 1 cycle -> total 8 cycles; ir_write one cycle; reg_write with wb_sel=01 once.
- Branches:
  - BEQ funct3=000, zero=1 -> pc_write in BR_TGT with a=10, b=10.
  - BNE with zero=1 -> no pc_write, still retires.
- JAL -> 3 cycles; pc_write, reg_write, wb_sel=10 asserted together in the JAL cycle.
- Illegal opcode 1111111 -> trap=1 held 5 cycles until trap_ack, then FETCH; instret unchanged. Repeat with TRAP_ON_ILLEGAL=0 -> retires, no trap.
- rst asserted during MEM_STORE with mem_ready=0 -> next cycle mem_req=0, state FETCH, instret=0. Also INSTRET_W=4: 16 retires wrap to 0.
